io_peripherals: RTL and testbench



---
 rtl/io_peripherals.sv | 169 ++++++++++++++++
 tb/tb_io_peripherals.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_peripherals.sv
// io_peripherals
//   Memory-mapped responder for the board I/O. It answers processor loads and
//   stores on the data bus, samples the slide switches, debounces the
//   push-button into a sticky press flag, and drives the LEDs and the six
//   seven-segment digits from processor-written registers.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   re, we            one-cycle read / write strobes
//   addr[7:0]         byte address; addr[4:2] selects the register, [1:0] ignored
//   wdata[31:0]       write data
//   rdata[31:0]       registered read data, held until the next read
//   button            asynchronous push-button, active-high
//   switches[9:0]     asynchronous slide switches
//   leds[9:0]         LED drive, active-high
//   hex0..hex5[6:0]   seven-segment drive, active-low gfedcba, hex0 rightmost
//
// Register map (addr[7:5] must be 0):
//   0 SW (RO)  1 BTN (RO: bit0 press flag, bit1 level)  2 LED (RW)
//   3 HEXVAL (RW)  4 HEXBLANK (RW, reset all blanked)  5-7 read 0
module io_peripherals #(
    parameter int unsigned DEBOUNCE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        re,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        button,
    input  logic [9:0]  switches,
    output logic [9:0]  leds,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1: acceptance happens on the
    // cycle that would have been the DEBOUNCE_CYCLES-th disagreeing sample.
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        REG_SW       = 3'd0,
        REG_BTN      = 3'd1,
        REG_LED      = 3'd2,
        REG_HEXVAL   = 3'd3,
        REG_HEXBLANK = 3'd4
    } reg_sel_t;

    logic [9:0]    sw_s1, sw_s2;
    logic          btn_s1, btn_s2;
    logic [CW-1:0] db_cnt;
    logic          btn_db;
    logic          press;
    logic [9:0]    led_r;
    logic [23:0]   hexval_r;
    logic [5:0]    hexblank_r;

    reg_sel_t      sel;
    logic          mapped;
    logic          btn_rd;
    logic          db_accept;
    logic [31:0]   rd_next;

    always_comb begin
        sel       = reg_sel_t'(addr[4:2]);
        mapped    = (addr[7:5] == 3'b000);
        btn_rd    = re && mapped && (sel == REG_BTN);
        db_accept = (btn_s2 != btn_db) && (db_cnt == CNT_LAST);
        rd_next   = '0;
        if (mapped) begin
            case (sel)
                REG_SW:       rd_next = {22'd0, sw_s2};
                REG_BTN:      rd_next = {30'd0, btn_db, press};
                REG_LED:      rd_next = {22'd0, led_r};
                REG_HEXVAL:   rd_next = {8'd0, hexval_r};
                REG_HEXBLANK: rd_next = {26'd0, hexblank_r};
                default:      rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1      <= '0;
            sw_s2      <= '0;
            btn_s1     <= 1'b0;
            btn_s2     <= 1'b0;
            db_cnt     <= '0;
            btn_db     <= 1'b0;
            press      <= 1'b0;
            led_r      <= '0;
            hexval_r   <= '0;
            hexblank_r <= '1;
            rdata      <= '0;
        end else begin
            sw_s1  <= switches;
            sw_s2  <= sw_s1;
            btn_s1 <= button;
            btn_s2 <= btn_s1;

            if (btn_s2 != btn_db) begin
                if (db_accept) begin
                    btn_db <= btn_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CW'(1);
                end
            end else begin
                db_cnt <= '0;
            end

            // A rising debounced edge on the same cycle as a BTN read keeps the flag.
            if (db_accept && btn_s2)
                press <= 1'b1;
            else if (btn_rd)
                press <= 1'b0;

            if (re)
                rdata <= rd_next;

            if (we && mapped) begin
                case (sel)
                    REG_LED:      led_r      <= wdata[9:0];
                    REG_HEXVAL:   hexval_r   <= wdata[23:0];
                    REG_HEXBLANK: hexblank_r <= wdata[5:0];
                    default:      ;
                endcase
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        leds = led_r;
        hex0 = hexblank_r[0] ? '1 : seg7(hexval_r[3:0]);
        hex1 = hexblank_r[1] ? '1 : seg7(hexval_r[7:4]);
        hex2 = hexblank_r[2] ? '1 : seg7(hexval_r[11:8]);
        hex3 = hexblank_r[3] ? '1 : seg7(hexval_r[15:12]);
        hex4 = hexblank_r[4] ? '1 : seg7(hexval_r[19:16]);
        hex5 = hexblank_r[5] ? '1 : seg7(hexval_r[23:20]);
    end

endmodule

// File: tb/tb_io_peripherals.sv
// Bench for io_peripherals: two instances (DEBOUNCE_CYCLES = 1 and 4) share
// the same stimulus; a behavioural model predicts both every cycle.
module tb_io_peripherals;

    logic        clk = 1'b0;
    logic        reset, re, we, button;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [9:0]  switches;

    logic [31:0] rd [2];
    logic [9:0]  ld [2];
    logic [6:0]  hx [2][6];

    int unsigned nchk = 0;
    int unsigned npass = 0;

    always #5 clk = ~clk;

    io_peripherals #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rd[0]), .button(button), .switches(switches), .leds(ld[0]),
        .hex0(hx[0][0]), .hex1(hx[0][1]), .hex2(hx[0][2]),
        .hex3(hx[0][3]), .hex4(hx[0][4]), .hex5(hx[0][5])
    );

    io_peripherals #(.DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rd[1]), .button(button), .switches(switches), .leds(ld[1]),
        .hex0(hx[1][0]), .hex1(hx[1][1]), .hex2(hx[1][2]),
        .hex3(hx[1][3]), .hex4(hx[1][4]), .hex5(hx[1][5])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int unsigned dcyc [2] = '{1, 4};

    logic [15:0] bh;          // button pin history, bh[0] = sampled this edge
    logic [9:0]  swh [3];     // switch pin history
    logic [9:0]  m_led [2];
    logic [23:0] m_hv  [2];
    logic [5:0]  m_hb  [2];
    logic        m_flag [2];
    logic        m_db  [2];
    logic [31:0] m_rd  [2];
    bit          mvalid = 0;

    always @(posedge clk) begin
        logic [31:0] rv;
        logic        newdb, all_diff, mapped;
        if (reset) begin
            bh = '0;
            for (int j = 0; j < 3; j++) swh[j] = '0;
            for (int i = 0; i < 2; i++) begin
                m_led[i] = '0; m_hv[i] = '0; m_hb[i] = 6'h3F;
                m_flag[i] = 1'b0; m_db[i] = 1'b0; m_rd[i] = '0;
            end
            mvalid = 1;
        end else begin
            bh = {bh[14:0], button};
            swh[2] = swh[1]; swh[1] = swh[0]; swh[0] = switches;
            mapped = (addr[7:5] == 3'd0);
            for (int i = 0; i < 2; i++) begin
                rv = 0;
                if (mapped) begin
                    case (addr[4:2])
                        3'd0: rv = {22'd0, swh[2]};
                        3'd1: rv = {30'd0, m_db[i], m_flag[i]};
                        3'd2: rv = {22'd0, m_led[i]};
                        3'd3: rv = {8'd0, m_hv[i]};
                        3'd4: rv = {26'd0, m_hb[i]};
                        default: rv = 0;
                    endcase
                end
                // the level flips once the last D synchronized samples all disagree with it
                all_diff = 1'b1;
                for (int j = 0; j < int'(dcyc[i]); j++)
                    if (bh[2+j] == m_db[i]) all_diff = 1'b0;
                newdb = all_diff ? ~m_db[i] : m_db[i];
                if (newdb && !m_db[i]) m_flag[i] = 1'b1;
                else if (re && mapped && addr[4:2] == 3'd1) m_flag[i] = 1'b0;
                m_db[i] = newdb;
                if (we && mapped) begin
                    if (addr[4:2] == 3'd2) m_led[i] = wdata[9:0];
                    if (addr[4:2] == 3'd3) m_hv[i]  = wdata[23:0];
                    if (addr[4:2] == 3'd4) m_hb[i]  = wdata[5:0];
                end
                if (re) m_rd[i] = rv;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("d%0d rdata", i), rd[i], m_rd[i]);
                chk($sformatf("d%0d leds", i), {22'd0, ld[i]}, {22'd0, m_led[i]});
                for (int k = 0; k < 6; k++) begin
                    logic [3:0] nib;
                    nib = m_hv[i][4*k +: 4];
                    chk($sformatf("d%0d hex%0d", i, k), {25'd0, hx[i][k]},
                        {25'd0, m_hb[i][k] ? 7'h7F : segtab[nib]});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic rdreg(input logic [7:0] a);
        re = 1'b1; addr = a;
        cyc();
        re = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rst_exp [5];
        rst_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3F};
        reset = 1'b1; re = 1'b0; we = 1'b0; button = 1'b0;
        addr = '0; wdata = '0; switches = '0;
        cyc(); cyc();
        reset = 1'b0;

        // reset state
        for (int i = 0; i < 2; i++) begin
            chk("rst leds", {22'd0, ld[i]}, 32'h0);
            for (int k = 0; k < 6; k++) chk("rst hex", {25'd0, hx[i][k]}, 32'h7F);
        end
        for (int r = 0; r < 5; r++) begin
            rdreg(8'(r * 4));
            for (int i = 0; i < 2; i++) chk("rst read", rd[i], rst_exp[r]);
        end

        // switches through the synchronizer
        switches = 10'h3FF; cyc(); cyc(); rdreg(8'h00);
        for (int i = 0; i < 2; i++) chk("sw 3ff", rd[i], 32'h3FF);
        switches = 10'b1110111101; cyc(); cyc(); rdreg(8'h00);
        for (int i = 0; i < 2; i++) chk("sw 3bd", rd[i], 32'h3BD);

        // LED and hex registers
        wr(8'h08, 32'hFFFFF2A5);
        for (int i = 0; i < 2; i++) chk("leds 2a5", {22'd0, ld[i]}, 32'h2A5);
        rdreg(8'h08);
        for (int i = 0; i < 2; i++) chk("rd led", rd[i], 32'h2A5);
        wr(8'h0C, 32'h000A8F30);
        wr(8'h10, 32'h0);
        for (int i = 0; i < 2; i++) begin
            chk("hex5", {25'd0, hx[i][5]}, 32'h40);
            chk("hex4", {25'd0, hx[i][4]}, 32'h08);
            chk("hex3", {25'd0, hx[i][3]}, 32'h00);
            chk("hex2", {25'd0, hx[i][2]}, 32'h0E);
            chk("hex1", {25'd0, hx[i][1]}, 32'h30);
            chk("hex0", {25'd0, hx[i][0]}, 32'h40);
        end

        // 1-cycle pulse: accepted by D=1, rejected by D=4
        button = 1'b1; cyc(); button = 1'b0;
        repeat (5) cyc();
        rdreg(8'h04);
        chk("d1 pulse flag", rd[0], 32'h1);
        chk("d4 short pulse", rd[1], 32'h0);
        rdreg(8'h04);
        chk("d1 flag cleared", rd[0], 32'h0);

        // press lands on the clearing read edge: read sees 0, flag survives
        button = 1'b1; cyc(); cyc();
        rdreg(8'h04);
        chk("d1 set-vs-clr rd", rd[0], 32'h0);
        button = 1'b0;
        repeat (6) cyc();
        rdreg(8'h04);
        chk("d1 set wins", rd[0], 32'h1);
        chk("d4 3-cyc pulse", rd[1], 32'h0);
        repeat (4) cyc();

        // 6-cycle pulse on D=4: level and flag appear on edge 6
        for (int k = 1; k <= 8; k++) begin
            button = (k <= 6);
            re = (k == 6 || k == 7);
            addr = 8'h04;
            cyc();
            if (k == 6) chk("d4 edge6 pre", rd[1], 32'h0);
            if (k == 7) chk("d4 edge7 set", rd[1], 32'h3);
        end
        re = 1'b0;
        repeat (10) cyc();

        // blanking, unmapped addresses
        wr(8'h10, 32'h21);
        for (int i = 0; i < 2; i++) begin
            chk("blank hex5", {25'd0, hx[i][5]}, 32'h7F);
            chk("blank hex0", {25'd0, hx[i][0]}, 32'h7F);
            chk("unblank hex1", {25'd0, hx[i][1]}, 32'h30);
        end
        rdreg(8'h1C);
        for (int i = 0; i < 2; i++) chk("rd 1c", rd[i], 32'h0);
        wr(8'h1C, 32'hFFFFFFFF);
        wr(8'h28, 32'h0);
        for (int i = 0; i < 2; i++) chk("unmapped wr", {22'd0, ld[i]}, 32'h2A5);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] pick;
            re = ($urandom_range(0, 2) == 0);
            we = ($urandom_range(0, 3) == 0);
            pick = 4'($urandom_range(0, 9));
            addr = (pick < 8) ? {3'b000, pick[2:0], 2'($urandom)} : 8'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 15) == 0) switches = 10'($urandom);
            if ($urandom_range(0, 6) == 0) button = ~button;
            cyc();
        end

        // reset mid-operation beats concurrent re/we
        button = 1'b1;
        wr(8'h08, 32'h155);
        wr(8'h10, 32'h0);
        re = 1'b1; we = 1'b1; addr = 8'h08; wdata = 32'h3FF; reset = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk("midrst rdata", rd[i], 32'h0);
            chk("midrst leds", {22'd0, ld[i]}, 32'h0);
            for (int k = 0; k < 6; k++) chk("midrst hex", {25'd0, hx[i][k]}, 32'h7F);
        end
        reset = 1'b0; re = 1'b0; we = 1'b0; button = 1'b0;
        repeat (8) cyc();
        rdreg(8'h04);
        for (int i = 0; i < 2; i++) chk("midrst btn", rd[i], 32'h0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
